// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_entry_t : one buffered fetch result, {pc, inst}
//   HALT_INST     : instruction word that stops further fetching
//   is_halt()     : true when a word is the halt word
package fetch_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   localparam logic [31:0] HALT_INST = 32'h0000_0000;

   function automatic logic is_halt(input logic [31:0] inst);
      return (inst == HALT_INST);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO of fetch_entry_t with flush.
//   clk, rst  : clock and asynchronous active-low reset (clears storage too,
//               so the head reads as zero while in reset)
//   push      : write push_data at the tail
//   pop       : drop the head entry
//   flush     : empty the FIFO; overrides push and pop
//   head      : entry at the head (meaningful when count != 0)
//   count     : occupancy at the start of the cycle
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   input  logic                         flush,
   output fetch_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t   mem_r [DEPTH];
   logic [PW-1:0]  wr_ptr_r;
   logic [PW-1:0]  rd_ptr_r;
   logic [CW-1:0]  count_r;

   // Pointers wrap explicitly so DEPTH need not be a power of two
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? PW'(0) : p + PW'(1);
   endfunction

   // Storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (pop) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

   fetch_fifo_chk #(.DEPTH(DEPTH)) u_chk (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .count (count_r)
   );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Protocol checker for fetch_fifo; carries no design logic.
//   clk, rst : clock and asynchronous active-low reset
//   push/pop : FIFO handshakes
//   count    : FIFO occupancy
module fetch_fifo_chk #(
   parameter int DEPTH = 4
) (
   input logic                         clk,
   input logic                         rst,
   input logic                         push,
   input logic                         pop,
   input logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);

   // The credit rule must always leave room for a returning response
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && (count == CW'(DEPTH))));

   // Decode can only take what is there
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
      !(pop && (count == CW'(0))));

endmodule

// File: rtl/inst_fetch_queue.sv
// IF stage of the 5-stage MIPS pipeline: owns the fetch PC, issues word
// fetches to instruction memory and buffers {pc, inst} pairs for decode.
//   clk, rst               : clock, asynchronous active-low reset
//   imem_req/imem_addr     : fetch request and word address
//   imem_rvalid/imem_inst  : response, exactly one cycle after a request
//   redirect/redirect_pc   : flush and restart fetch (branch, j, jr)
//   out_valid/out_ready    : head entry handshake towards decode
//   out_pc/out_inst        : head entry contents
//   halt_seen              : halt word enqueued, fetching frozen
module inst_fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_inst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        halt_seen
);

   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc_r;
   logic [31:0]   req_pc_r;
   logic          inflight_r;
   logic          halt_seen_r;

   logic [CW-1:0] count_s;
   logic          push_s;
   logic          pop_s;
   logic          halt_in_s;
   logic          credit_s;
   logic          req_s;
   logic          valid_s;
   fetch_entry_t  push_data_s;
   fetch_entry_t  head_s;

   // Issue/credit and handshake logic. A response is only honoured while
   // one is outstanding, so a stale response after reset is ignored. Credit
   // uses start-of-cycle occupancy, reserving a slot per in-flight fetch.
   always_comb begin
      push_s           = imem_rvalid & inflight_r & ~redirect;
      halt_in_s        = imem_rvalid & inflight_r & is_halt(imem_inst);
      credit_s         = (({1'b0, count_s} + {{CW{1'b0}}, inflight_r}) < DEPTH_C);
      req_s            = rst & ~redirect & ~halt_seen_r & ~halt_in_s & credit_s;
      valid_s          = (count_s != CW'(0)) & ~redirect;
      pop_s            = valid_s & out_ready;
      push_data_s.pc   = req_pc_r;
      push_data_s.inst = imem_inst;
   end

   // Fetch PC, outstanding-request tracking and halt state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_r  <= RESET_PC;
         req_pc_r    <= 32'h0000_0000;
         inflight_r  <= 1'b0;
         halt_seen_r <= 1'b0;
      end else begin
         inflight_r <= req_s;
         if (redirect) begin
            fetch_pc_r  <= redirect_pc & ~32'h0000_0003;
            halt_seen_r <= 1'b0;
         end else begin
            if (req_s) begin
               fetch_pc_r <= fetch_pc_r + 32'd4;
               req_pc_r   <= fetch_pc_r;
            end
            if (push_s && is_halt(imem_inst)) begin
               halt_seen_r <= 1'b1;
            end
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .flush     (redirect),
      .head      (head_s),
      .count     (count_s)
   );

   assign imem_req  = req_s;
   assign imem_addr = fetch_pc_r;
   assign out_valid = valid_s;
   assign out_pc    = head_s.pc;
   assign out_inst  = head_s.inst;
   assign halt_seen = halt_seen_r;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios followed by a
// randomized phase, all checked every cycle against a queue-based model.
module tb_inst_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_inst   = 32'h0;
   logic        redirect    = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready   = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        halt_seen;

   int n_checks = 0;
   int n_fails  = 0;

   // reference model state
   ent_t        mq[$];
   logic [31:0] m_pc       = RESET_PC;
   logic [31:0] m_req_pc   = 32'h0;
   logic        m_inflight = 1'b0;
   logic        m_halt     = 1'b0;
   int          deliv      = 0;
   logic [31:0] got_pc[$];

   // memory responder state
   logic        resp_pend = 1'b0;
   logic [31:0] resp_inst = 32'h0;
   logic [31:0] halt_addr = 32'hFFFF_FFF0;
   logic        late_inj  = 1'b0;

   always #5 clk = ~clk;

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_inst   (imem_inst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_inst    (out_inst),
      .halt_seen   (halt_seen)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == halt_addr) return 32'h0000_0000;
      return {8'h24, a[23:0]};
   endfunction

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc       = RESET_PC;
      m_inflight = 1'b0;
      m_halt     = 1'b0;
   endtask

   // One clock cycle: drive inputs on the falling edge, check, then advance the model.
   task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
      logic e_push, e_halt_resp, e_req, e_valid;
      @(negedge clk);
      out_ready   = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      if (late_inj) begin
         imem_rvalid = 1'b1;
         imem_inst   = 32'h1234_5678;
         late_inj    = 1'b0;
      end else begin
         imem_rvalid = resp_pend;
         imem_inst   = resp_pend ? resp_inst : 32'h0;
      end
      #1;
      e_push      = rst & imem_rvalid & m_inflight & ~redir;
      e_halt_resp = imem_rvalid & m_inflight & (imem_inst == 32'h0);
      e_req       = rst & ~redir & ~m_halt & ~e_halt_resp & ((mq.size() + int'(m_inflight)) < DEPTH);
      e_valid     = rst & (mq.size() != 0) & ~redir;
      check_val("imem_req",  {31'h0, imem_req},  {31'h0, e_req});
      check_val("imem_addr", imem_addr, m_pc);
      check_val("out_valid", {31'h0, out_valid}, {31'h0, e_valid});
      check_val("halt_seen", {31'h0, halt_seen}, {31'h0, m_halt});
      if (e_valid) begin
         check_val("out_pc",   out_pc,   mq[0].pc);
         check_val("out_inst", out_inst, mq[0].inst);
      end
      resp_pend = imem_req;
      resp_inst = mem_word(imem_addr);
      @(posedge clk);
      if (!rst) begin
         model_reset();
      end else if (redir) begin
         mq.delete();
         m_halt     = 1'b0;
         m_pc       = rpc & ~32'h3;
         m_inflight = 1'b0;
      end else begin
         if (e_valid && rdy) begin
            got_pc.push_back(mq[0].pc);
            void'(mq.pop_front());
            deliv++;
         end
         if (e_push) begin
            mq.push_back(ent_t'{pc: m_req_pc, inst: imem_inst});
            if (imem_inst == 32'h0) m_halt = 1'b1;
         end
         if (e_req) begin
            m_req_pc = m_pc;
            m_pc     = m_pc + 32'd4;
         end
         m_inflight = e_req;
      end
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      model_reset();
      repeat (3) cycle(1'b0, 1'b0, 32'h0);
      #2 rst = 1'b1;
      deliv = 0;
      got_pc.delete();
   endtask

   initial begin
      // 1: reset held three cycles, then release
      repeat (3) cycle(1'b0, 1'b0, 32'h0);
      #2 rst = 1'b1;
      deliv = 0;

      // 2: free-running stream, one delivery per cycle from cycle 2
      repeat (20) cycle(1'b1, 1'b0, 32'h0);
      check_val("stream_count", deliv, 32'd18);

      // 3: back-pressure for 8 cycles, then drain
      do_reset();
      repeat (8) cycle(1'b0, 1'b0, 32'h0);
      repeat (8) cycle(1'b1, 1'b0, 32'h0);
      check_val("bp_count", deliv, 32'd8);
      check_val("bp_last_pc", got_pc[got_pc.size()-1], 32'h1C);

      // 4: redirect with three queued and one in flight
      do_reset();
      repeat (4) cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 32'h40);
      got_pc.delete();
      repeat (6) cycle(1'b1, 1'b0, 32'h0);
      check_val("redir_first_pc", got_pc[0], 32'h40);

      // 5: halt word at 0x0C, then redirect to 0x20
      halt_addr = 32'h0000_000C;
      do_reset();
      repeat (10) cycle(1'b1, 1'b0, 32'h0);
      check_val("halt_flag", {31'h0, halt_seen}, 32'h1);
      check_val("halt_count", deliv, 32'd4);
      check_val("halt_last_pc", got_pc[got_pc.size()-1], 32'h0C);
      cycle(1'b1, 1'b1, 32'h20);
      got_pc.delete();
      repeat (6) cycle(1'b1, 1'b0, 32'h0);
      check_val("halt_cleared", {31'h0, halt_seen}, 32'h0);
      check_val("resume_pc", got_pc[0], 32'h20);
      halt_addr = 32'hFFFF_FFF0;

      // unaligned redirect near the top of the address space, PC wraps
      cycle(1'b1, 1'b1, 32'hFFFF_FFF9);
      repeat (6) cycle(1'b1, 1'b0, 32'h0);

      // 6: asynchronous reset between clock edges, stale response afterwards
      do_reset();
      repeat (5) cycle(1'b1, 1'b0, 32'h0);
      #3 rst = 1'b0;
      #1;
      check_val("arst_req",   {31'h0, imem_req},  32'h0);
      check_val("arst_valid", {31'h0, out_valid}, 32'h0);
      check_val("arst_pc",    out_pc,   32'h0);
      check_val("arst_inst",  out_inst, 32'h0);
      check_val("arst_addr",  imem_addr, RESET_PC);
      model_reset();
      repeat (2) cycle(1'b1, 1'b0, 32'h0);
      #2 rst = 1'b1;
      late_inj = 1'b1;
      got_pc.delete();
      repeat (5) cycle(1'b1, 1'b0, 32'h0);
      check_val("arst_first_pc", got_pc[0], RESET_PC);

      // randomized phase
      halt_addr = 32'h0000_0064;
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < 4)  ? 1'b1 : 1'b0,
               32'($urandom_range(0, 255)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
